// File: rtl/wb_trace_buffer.sv
// Commit-trace FIFO behind the writeback debug port: tags each register-write
// retirement with a sequence number and streams it out over a valid/ready port.
module wb_trace_buffer #(
  parameter int DEPTH      = 8,
  parameter bit CAPTURE_X0 = 1'b0,
  parameter int SEQ_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     debug_RegWrite,
  input  logic [4:0]               debug_WA,
  input  logic [31:0]              debug_WB,
  input  logic [31:0]              debug_inst,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [SEQ_W-1:0]         trace_seq,
  output logic [31:0]              trace_inst,
  output logic [4:0]               trace_wa,
  output logic [31:0]              trace_wb,
  output logic [$clog2(DEPTH):0]   level,
  output logic [SEQ_W-1:0]         drop_cnt,
  output logic                     overflow,
  input  logic                     clr_stats
);

  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = PW + 1;
  localparam int ENT_W = SEQ_W + 32 + 5 + 32;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0]    level_q, level_nxt;
  logic [SEQ_W-1:0] seq_q;
  logic             cap, full, pop, push, drop, bypass;
  logic [ENT_W-1:0] new_ent, head_nxt;

  function automatic logic [SEQ_W-1:0] sat_inc(input logic [SEQ_W-1:0] v);
    return (&v) ? v : v + SEQ_W'(1);
  endfunction

  always_comb begin
    cap       = en & debug_RegWrite & (CAPTURE_X0 | (debug_WA != 5'd0));
    full      = (level_q == LW'(DEPTH));
    pop       = trace_valid & trace_ready;
    push      = cap & (!full | pop);
    drop      = cap & full & !pop;
    new_ent   = {seq_q, debug_inst, debug_WA, debug_WB};
    rd_nxt    = pop ? rd_ptr + PW'(1) : rd_ptr;
    level_nxt = level_q;
    if (push && !pop)
      level_nxt = level_q + LW'(1);
    else if (pop && !push)
      level_nxt = level_q - LW'(1);
    // The new entry becomes head when the FIFO is, or is about to be, empty;
    // its memory slot is only written at this same edge.
    bypass    = push & ((level_q == '0) | ((level_q == LW'(1)) & pop));
    head_nxt  = bypass ? new_ent : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= new_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      rd_ptr  <= rd_nxt;
      level_q <= level_nxt;
      if (cap)
        seq_q <= seq_q + SEQ_W'(1);
      if (clr_stats) begin
        drop_cnt <= '0;
        overflow <= 1'b0;
      end else if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
        overflow <= 1'b1;
      end
    end
  end

  // Head register stage: outputs hold their last value once the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_seq   <= '0;
      trace_inst  <= '0;
      trace_wa    <= '0;
      trace_wb    <= '0;
    end else begin
      trace_valid <= (level_nxt != '0);
      if (level_nxt != '0)
        {trace_seq, trace_inst, trace_wa, trace_wb} <= head_nxt;
    end
  end

  assign level = level_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed table-driven bench for wb_trace_buffer: a default instance (DEPTH=8)
// and a tiny instance (DEPTH=2, x0 capture, 2-bit counters) for wrap/saturation.
module tb_wb_trace_buffer;

  localparam logic [31:0] INST_KEY = 32'h02A0_0000;

  logic        clk, rst_n, rst_n2;
  logic        en, rw, rdy, clr;
  logic [4:0]  wa;
  logic [31:0] wb, inst;

  logic        tv1, ov1, tv2, ov2;
  logic [15:0] ts1, dc1;
  logic [31:0] ti1, twb1, ti2, twb2;
  logic [4:0]  twa1, twa2;
  logic [3:0]  lvl1;
  logic [1:0]  ts2, dc2, lvl2;

  int checks = 0;
  int failures = 0;

  wb_trace_buffer #(.DEPTH(8), .CAPTURE_X0(1'b0), .SEQ_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .debug_RegWrite(rw), .debug_WA(wa),
    .debug_WB(wb), .debug_inst(inst), .trace_valid(tv1), .trace_ready(rdy),
    .trace_seq(ts1), .trace_inst(ti1), .trace_wa(twa1), .trace_wb(twb1),
    .level(lvl1), .drop_cnt(dc1), .overflow(ov1), .clr_stats(clr)
  );

  wb_trace_buffer #(.DEPTH(2), .CAPTURE_X0(1'b1), .SEQ_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .en(en), .debug_RegWrite(rw), .debug_WA(wa),
    .debug_WB(wb), .debug_inst(inst), .trace_valid(tv2), .trace_ready(rdy),
    .trace_seq(ts2), .trace_inst(ti2), .trace_wa(twa2), .trace_wb(twb2),
    .level(lvl2), .drop_cnt(dc2), .overflow(ov2), .clr_stats(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic        en, rw, rdy, clr;
    logic [4:0]  wa;
    logic [31:0] wb;
    logic        ev, eovf;
    logic [15:0] eseq, edrop;
    logic [4:0]  ewa;
    logic [31:0] ewb;
    logic [3:0]  elvl;
  } vec_t;

  vec_t tbl[$];
  logic cur_sel;

  task automatic add(input int e, input int r, input int a, input logic [31:0] d,
                     input int rd, input int c, input int ev, input int eseq,
                     input int ewa, input logic [31:0] ewb, input int elvl,
                     input int edrop, input int eovf);
    vec_t v;
    v.sel = cur_sel;      v.en = 1'(e);      v.rw = 1'(r);    v.wa = 5'(a);
    v.wb = d;             v.rdy = 1'(rd);    v.clr = 1'(c);   v.ev = 1'(ev);
    v.eseq = 16'(eseq);   v.ewa = 5'(ewa);   v.ewb = ewb;     v.elvl = 4'(elvl);
    v.edrop = 16'(edrop); v.eovf = 1'(eovf);
    tbl.push_back(v);
  endtask

  task automatic drive(input logic e, input logic r, input logic [4:0] a,
                       input logic [31:0] d, input logic rd, input logic c);
    en = e; rw = r; wa = a; wb = d; inst = d ^ INST_KEY; rdy = rd; clr = c;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packed as {valid, seq, wa, wb, level, drop_cnt, overflow}.
  task automatic cmp(input string name, input logic sel, input logic ev,
                     input logic [15:0] eseq, input logic [4:0] ewa,
                     input logic [31:0] ewb, input logic [3:0] elvl,
                     input logic [15:0] edrop, input logic eovf);
    logic [74:0] act, exp;
    logic [31:0] ainst;
    if (!sel) begin
      act = {tv1, ts1, twa1, twb1, lvl1, dc1, ov1};
      ainst = ti1;
    end else begin
      act = {tv2, 14'd0, ts2, twa2, twb2, 2'd0, lvl2, 14'd0, dc2, ov2};
      ainst = ti2;
    end
    exp = {ev, eseq, ewa, ewb, elvl, edrop, eovf};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got v=%b seq=%0d wa=%0d wb=%h lvl=%0d drop=%0d ovf=%b expected v=%b seq=%0d wa=%0d wb=%h lvl=%0d drop=%0d ovf=%b",
               name, act[74], act[73:58], act[57:53], act[52:21], act[20:17], act[16:1], act[0],
               ev, eseq, ewa, ewb, elvl, edrop, eovf);
    end
    if (ev)
      chk32({name, "_inst"}, ainst, ewb ^ INST_KEY);
  endtask

  task automatic run_rows(input logic sel);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].sel == sel) begin
        drive(tbl[i].en, tbl[i].rw, tbl[i].wa, tbl[i].wb, tbl[i].rdy, tbl[i].clr);
        @(posedge clk);
        @(negedge clk);
        cmp($sformatf("row%0d", i), sel, tbl[i].ev, tbl[i].eseq, tbl[i].ewa,
            tbl[i].ewb, tbl[i].elvl, tbl[i].edrop, tbl[i].eovf);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rst_n2 = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // Default instance: capture, hold, x0 filter, fill/overflow, full push+pop,
    // clear-vs-drop, drain order, level-1 push+pop, refill to 5.
    cur_sel = 1'b0;
    add(1,1,5,'h2A,0,0, 1,0,5,'h2A,1,0,0);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0,0, 1,0,5,'h2A,1,0,0);
    add(1,0,0,0,1,0, 0,0,5,'h2A,0,0,0);
    add(1,1,0,'h77,0,0, 0,0,5,'h2A,0,0,0);
    add(1,1,1,'h11,0,0, 1,1,1,'h11,1,0,0);
    add(0,1,3,'h33,1,0, 0,1,1,'h11,0,0,0);
    for (int k = 0; k < 10; k++)
      add(1,1,k+2,'h100+k,0,0, 1,2,2,'h100, (k<8)?k+1:8, (k<8)?0:k-7, (k>=8)?1:0);
    add(1,1,20,'h200,1,0, 1,3,3,'h101,8,2,1);
    add(1,1,21,'h201,0,0, 1,3,3,'h101,8,3,1);
    add(1,1,22,'h202,0,1, 1,3,3,'h101,8,0,0);
    for (int p = 1; p <= 6; p++) add(0,0,0,0,1,0, 1,3+p,3+p,'h101+p,8-p,0,0);
    add(0,0,0,0,1,0, 1,12,20,'h200,1,0,0);
    add(0,0,0,0,1,0, 0,12,20,'h200,0,0,0);
    add(1,1,7,'h300,0,0, 1,15,7,'h300,1,0,0);
    add(1,1,8,'h301,1,0, 1,16,8,'h301,1,0,0);
    for (int k = 0; k < 4; k++) add(1,1,9+k,'h400+k,0,0, 1,16,8,'h301,2+k,0,0);

    // Tiny instance: x0 capture, saturation at 3, sequence wrap mod 4.
    cur_sel = 1'b1;
    add(1,1,0,'hE0,0,0, 1,0,0,'hE0,1,0,0);
    add(1,1,1,'hE1,0,0, 1,0,0,'hE0,2,0,0);
    add(1,1,2,'hE2,0,0, 1,0,0,'hE0,2,1,1);
    add(1,1,3,'hE3,0,0, 1,0,0,'hE0,2,2,1);
    add(1,1,4,'hE4,0,0, 1,0,0,'hE0,2,3,1);
    add(1,1,5,'hE5,0,0, 1,0,0,'hE0,2,3,1);
    add(0,0,0,0,1,0, 1,1,1,'hE1,1,3,1);
    add(1,1,6,'hE6,0,0, 1,1,1,'hE1,2,3,1);
    add(0,0,0,0,1,0, 1,2,6,'hE6,1,3,1);
    add(0,0,0,0,1,1, 0,2,6,'hE6,0,0,0);
    add(1,1,7,'hE7,0,0, 1,3,7,'hE7,1,0,0);
    add(1,1,8,'hE8,1,0, 1,0,8,'hE8,1,0,0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("reset_state", 1'b0, 0, 0, 0, 0, 0, 0, 0);
    chk32("reset_inst", ti1, 32'd0);

    run_rows(1'b0);

    // Asynchronous reset between edges with five entries buffered.
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst", 1'b0, 0, 0, 0, 0, 0, 0, 0);
    chk32("async_rst_inst", ti1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 3, 32'h55, 0, 0);
    @(posedge clk);
    @(negedge clk);
    cmp("post_rst_cap", 1'b0, 1, 0, 3, 32'h55, 1, 0, 0);

    drive(0, 0, 0, 0, 0, 0);
    rst_n2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmp("reset_state2", 1'b1, 0, 0, 0, 0, 0, 0, 0);
    run_rows(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
Commit-trace buffer that sits directly downstream of the core's writeback debug port (debug_WB, debug_WA, debug_inst, debug_RegWrite).
- Captures each qualifying register-write retirement into a FIFO and streams it out over a valid/ready trace port.
- Tags every capture with a sequence number and counts captures dropped when the FIFO is full.
- Decouples a slow trace consumer (UART dumper, bench scoreboard) from the single-cycle writeback stream.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2.
CAPTURE_X0, 0, 1 = also capture writes with debug_WA == 0; 0 = ignore them.
SEQ_W, 16, width of sequence tag and drop counter.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  capture enable.
debug_RegWrite  input  1  writeback register-write strobe.
debug_WA  input  5  writeback destination register.
debug_WB  input  32  writeback data.
debug_inst  input  32  retiring instruction word.
trace_valid  output  1  head entry available.
trace_ready  input  1  consumer accepts head.
trace_seq  output  SEQ_W  sequence tag of head entry.
trace_inst  output  32  instruction of head entry.
trace_wa  output  5  destination register of head entry.
trace_wb  output  32  write data of head entry.
level  output  $clog2(DEPTH)+1  current occupancy.
drop_cnt  output  SEQ_W  captures lost to full FIFO (saturating).
overflow  output  1  sticky: at least one drop since reset/clear.
clr_stats  input  1  synchronous clear of drop_cnt and overflow.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO pointers and level = 0, trace_valid = 0, all trace_* data outputs = 0, sequence counter = 0, drop_cnt = 0, overflow = 0. Any buffered entries are discarded. Deassertion is synchronised externally; the block sees a clean edge.
- Capture qualifier: cap = en & debug_RegWrite & (CAPTURE_X0 | (debug_WA != 0)), sampled at the rising edge of clk.
- Sequence counter:
  - Increments by 1 on every cap, whether the entry is stored or dropped.
  - Wraps modulo 2^SEQ_W.
  - A stored entry carries the counter value before the increment. A gap in trace_seq therefore exposes drops.
- Push: cap & (!full | pop). Writing into a full FIFO is legal when a pop occurs in the same cycle.
- Pop: trace_valid & trace_ready.
- Simultaneous push and pop: level unchanged. When level is 1, the new entry becomes head on the next cycle.
- Output timing:
  - Show-ahead FIFO: trace_* always present the head entry. trace_valid = (level != 0), driven from a register.
  - Capture at edge N makes trace_valid high and the data visible after edge N, i.e. 1-cycle latency into an empty FIFO.
  - Data outputs hold their last value while trace_valid = 0.
- Handshake: while trace_valid is high and trace_ready is low, trace_* stay stable. trace_valid never drops without a pop.
- Drop: cap & full & !pop. drop_cnt increments, saturating at 2^SEQ_W-1, and overflow is set to 1. The entry is discarded and FIFO contents are unchanged.
- clr_stats: next cycle drop_cnt = 0 and overflow = 0. Clear beats a same-cycle drop; that drop is not counted, but its sequence number is still consumed. FIFO contents and the sequence counter are unaffected.
- en = 0: no captures and no sequence increment. The output side continues draining.
- Pointers: $clog2(DEPTH) bits, wrapping naturally. Full/empty are derived from level, which ranges 0..DEPTH.

Test Plan:
- Reset then single capture: en=1, RegWrite=1, WA=5, WB=0x0000_002A, inst=0x02A0_0293, trace_ready=0 -> next cycle trace_valid=1, seq=0, wa=5, wb=0x2A, level=1. Hold 3 cycles -> outputs stable. Ready=1 for one cycle -> valid=0, level=0.
- x0 filter with CAPTURE_X0=0: RegWrite=1, WA=0 -> no capture, seq not advanced. Next capture with WA=1 carries seq=0.
- Fill and overflow with DEPTH=8, ready=0: 10 consecutive captures -> level=8, drop_cnt=2, overflow=1. Draining yields seq 0..7. Next capture carries seq=10.
- Full with simultaneous push and pop: level=8, ready=1, capture in the same cycle -> drop_cnt unchanged, level stays 8, newest entry appears last in the drain order.
- clr_stats coinciding with a drop: overflow=1, drop_cnt=3, clr_stats=1 with cap while full -> next cycle drop_cnt=0, overflow=0. The following capture's seq shows a skip of 1.
- Asynchronous reset mid-stream: level=5, rst_n pulsed low between edges -> trace_valid=0, level=0, drop_cnt=0 immediately. First post-reset capture carries seq=0.
